// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared signed fixed-point format constants
package fp_pkg;
    localparam int FP_WL = 32;              // total word length
    localparam int FP_QW = 16;              // fractional bits
    localparam int FP_IW = FP_WL - FP_QW;   // integer bits, sign included
endpackage

// File: rtl/rt_pixel_seq_if.sv
// rtl/rt_pixel_seq_if.sv - coordinate stream from the pixel sequencer to the ray generator
//   x, y       : fixed-point column/row (fp_pkg format)
//   sample_idx : sample number within the pixel
//   valid/ready: handshake, last marks the final coordinate of a frame
interface rt_pixel_seq_if #(
    parameter int SPP_W = 4
) ();
    import fp_pkg::*;

    logic [FP_WL-1:0] x;
    logic [FP_WL-1:0] y;
    logic [SPP_W-1:0] sample_idx;
    logic             valid;
    logic             ready;
    logic             last;

    modport master (output x, y, sample_idx, valid, last, input ready);
    modport slave  (input x, y, sample_idx, valid, last, output ready);
endinterface

// File: rtl/rt_pixel_seq.sv
// rtl/rt_pixel_seq.sv - walks every (x, y, sample) of a frame and streams the coordinates
//   clk, rst      : clock, asynchronous active-high reset
//   start, abort  : begin a frame (IDLE only) / cancel a running frame
//   img_width/height, spp : frame geometry, latched at start (spp 0 means 1)
//   coord         : coordinate stream, master side
//   busy, done    : running indicator, one-cycle completion pulse
//   stall_cnt     : RUN cycles with valid && !ready, only when RT_PIXEL_SEQ_STALL_CNT_EN is defined
module rt_pixel_seq
    import fp_pkg::*;
#(
    parameter int DIM_W = 11,
    parameter int SPP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    input  logic [SPP_W-1:0] spp,
    rt_pixel_seq_if.master   coord,
    output logic             busy,
    output logic             done
`ifdef RT_PIXEL_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    // The counter must fit the integer field without touching the sign bit,
    // which is what lets x/y be a plain shift with no saturation.
    generate
        if (DIM_W > FP_IW - 1) begin : g_dim_chk
            $error("rt_pixel_seq: DIM_W exceeds fixed-point integer field");
        end
    endgenerate

    localparam int PAD_W = FP_WL - DIM_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
    logic [SPP_W-1:0] spp_q, spp_d;
    logic [DIM_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [SPP_W-1:0] cs_q, cs_d;
    logic             run;
    logic             is_last;
    logic             hs;

    assign run     = (state_q == S_RUN);
    assign is_last = run && (cx_q == w_q - DIM_W'(1)) && (cy_q == h_q - DIM_W'(1))
                         && (cs_q == spp_q - SPP_W'(1));
    assign hs      = run && coord.ready;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        spp_d   = spp_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        cs_d    = cs_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_d     = img_width;
                    h_d     = img_height;
                    spp_d   = (spp == '0) ? SPP_W'(1) : spp;
                    cx_d    = '0;
                    cy_d    = '0;
                    cs_d    = '0;
                    state_d = (img_width != '0 && img_height != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // abort wins over a handshake in the same cycle
                if (abort) begin
                    state_d = S_IDLE;
                end else if (hs) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else if (cs_q == spp_q - SPP_W'(1)) begin
                        cs_d = '0;
                        if (cx_q == w_q - DIM_W'(1)) begin
                            cx_d = '0;
                            cy_d = cy_q + DIM_W'(1);
                        end else begin
                            cx_d = cx_q + DIM_W'(1);
                        end
                    end else begin
                        cs_d = cs_q + SPP_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            h_q     <= '0;
            spp_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            cs_q    <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            spp_q   <= spp_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cs_q    <= cs_d;
        end
    end

    // valid/busy/last derive from the state register, so an asynchronous
    // reset removes them in the same instant.
    assign coord.valid      = run;
    assign coord.last       = is_last;
    assign coord.sample_idx = cs_q;
    assign coord.x          = {{PAD_W{1'b0}}, cx_q} << FP_QW;
    assign coord.y          = {{PAD_W{1'b0}}, cy_q} << FP_QW;
    assign busy             = run;
    assign done             = (state_q == S_DONE);

`ifdef RT_PIXEL_SEQ_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start) begin
            stall_d = '0;
        end else if (run && !coord.ready && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rt_pixel_seq.sv
// tb/tb_rt_pixel_seq.sv - scoreboard bench for rt_pixel_seq
module tb_rt_pixel_seq;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [10:0] img_width = '0;
    logic [10:0] img_height = '0;
    logic [3:0]  spp = '0;
    logic        busy, done;
`ifdef RT_PIXEL_SEQ_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    rt_pixel_seq_if #(.SPP_W(4)) coord ();

    rt_pixel_seq #(.DIM_W(11), .SPP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .img_width  (img_width),
        .img_height (img_height),
        .spp        (spp),
        .coord      (coord),
        .busy       (busy),
        .done       (done)
`ifdef RT_PIXEL_SEQ_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          done_seen = 0;
    int          done_base = 0;
    logic [79:0] exp_q[$];
    logic [79:0] held;
    logic        stalled = 1'b0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] cur_coord();
        return {11'b0, coord.x, coord.y, coord.sample_idx, coord.last};
    endfunction

    task automatic push_exp(input int xi, input int yi, input int si, input bit lst);
        exp_q.push_back({11'b0, 32'(xi * 65536), 32'(yi * 65536), 4'(si), lst});
    endtask

    task automatic push_frame(input int w, input int h, input int s);
        int se;
        se = (s == 0) ? 1 : s;
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                for (int ss = 0; ss < se; ss++)
                    push_exp(xx, yy, ss, (xx == w - 1) && (yy == h - 1) && (ss == se - 1));
    endtask

    // Monitor: pops the scoreboard on every accepted coordinate and checks hold during stalls.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (coord.valid && stalled)
                chk("stall_hold", cur_coord(), held);
            if (coord.valid && !coord.ready) begin
                stalled = 1'b1;
                held    = cur_coord();
            end else begin
                stalled = 1'b0;
            end
            if (coord.valid && coord.ready && !abort) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_coord: got %h expected none", cur_coord());
                end else begin
                    chk("coord", cur_coord(), exp_q.pop_front());
                end
            end
            if (done) done_seen++;
        end
    end

    task automatic start_frame(input int w, input int h, input int s);
        img_width  = 11'(w);
        img_height = 11'(h);
        spp        = 4'(s);
        done_base  = done_seen;
        start      = 1'b1;
        @(posedge clk);
        #1 start   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int cnt;
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (done) break;
        end
        chk({name, "_cycles"}, 80'(cnt), 80'(exp_cycles));
        @(posedge clk);
        #1;
        chk({name, "_idle"}, {78'b0, busy, done}, 80'b0);
        chk({name, "_sb_empty"}, 80'(exp_q.size()), 80'd0);
        chk({name, "_done_cnt"}, 80'(done_seen - done_base), 80'd1);
    endtask

    initial begin
        coord.ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {76'b0, coord.valid, coord.last, busy, done}, 80'b0);
        chk("rst_coord", cur_coord(), 80'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ctrl", {76'b0, coord.valid, coord.last, busy, done}, 80'b0);
`ifdef RT_PIXEL_SEQ_STALL_CNT_EN
        chk("rst_stall_cnt", 80'(stall_cnt), 80'd0);
`endif
        @(posedge clk);
        #1 coord.ready = 1'b1;

        // 3x2, one sample
        push_exp(0, 0, 0, 0); push_exp(1, 0, 0, 0); push_exp(2, 0, 0, 0);
        push_exp(0, 1, 0, 0); push_exp(1, 1, 0, 0); push_exp(2, 1, 0, 1);
        start_frame(3, 2, 1);
        wait_done("f3x2", 7);

        // 2x1, three samples, back to back
        push_exp(0, 0, 0, 0); push_exp(0, 0, 1, 0); push_exp(0, 0, 2, 0);
        push_exp(1, 0, 0, 0); push_exp(1, 0, 1, 0); push_exp(1, 0, 2, 1);
        start_frame(2, 1, 3);
        wait_done("f2x1s3", 7);

        // spp=0 behaves as 1
        push_exp(0, 0, 0, 0); push_exp(1, 0, 0, 1);
        start_frame(2, 1, 0);
        wait_done("f2x1s0", 3);

        // zero width: straight to DONE
        start_frame(0, 5, 1);
        wait_done("fzero", 1);

        // stall 4 cycles at (1,0)
        push_frame(3, 1, 1);
        start_frame(3, 1, 1);
        @(posedge clk);
        #1 coord.ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 coord.ready = 1'b1;
        wait_done("fstall", 3);
`ifdef RT_PIXEL_SEQ_STALL_CNT_EN
        chk("stall_cnt", 80'(stall_cnt), 80'd4);
`endif

        // abort on the 3rd coordinate
        push_exp(0, 0, 0, 0); push_exp(1, 0, 0, 0);
        start_frame(3, 2, 1);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_ctrl", {78'b0, coord.valid, busy}, 80'b0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 80'(done_seen - done_base), 80'd0);
        chk("abort_sb_empty", 80'(exp_q.size()), 80'd0);
        @(posedge clk);
        #1;
        push_frame(2, 1, 1);
        start_frame(2, 1, 1);
        wait_done("after_abort", 3);

        // reset mid-frame at column 5
        for (int c = 0; c < 5; c++) push_exp(c, 0, 0, 0);
        start_frame(6, 1, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("col5_x", {47'b0, coord.valid, coord.x}, {47'b0, 1'b1, 32'h0005_0000});
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", {76'b0, coord.valid, coord.last, busy, done}, 80'b0);
        chk("midrst_coord", cur_coord(), 80'b0);
`ifdef RT_PIXEL_SEQ_STALL_CNT_EN
        chk("midrst_stall_cnt", 80'(stall_cnt), 80'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_no_done", 80'(done_seen - done_base), 80'd0);
        chk("midrst_sb_empty", 80'(exp_q.size()), 80'd0);
        chk("midrst_idle", {78'b0, coord.valid, busy}, 80'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rt_pixel_seq.md
RT_PIXEL_SEQ -- requirements
Module: rt_pixel_seq

Interface
REQ-001 SHALL have parameter DIM_W, default 11: width of image dimension and pixel counters.
REQ-002 SHALL have parameter SPP_W, default 4: width of the samples-per-pixel count and sample index.
REQ-003 SHALL fail elaboration unless DIM_W <= FP_IW-1, where FP_IW and FP_WL come from the shared fixed-point package.
REQ-004 SHALL have port clk  input  1  the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  begins a frame when sampled high in IDLE; ignored otherwise.
REQ-007 SHALL have port abort  input  1  synchronous frame cancel.
REQ-008 SHALL have port img_width  input  DIM_W  pixel columns, latched at start.
REQ-009 SHALL have port img_height  input  DIM_W  pixel rows, latched at start.
REQ-010 SHALL have port spp  input  SPP_W  samples per pixel, latched at start; 0 is treated as 1.
REQ-011 SHALL have port x  output  FP_WL  current column as signed fixed-point, integer in the integer field, fraction zero.
REQ-012 SHALL have port y  output  FP_WL  current row, same format as x.
REQ-013 SHALL have port sample_idx  output  SPP_W  sample number within the current pixel.
REQ-014 SHALL have port valid  output  1  x/y/sample_idx/last hold a coordinate for the ray generator.
REQ-015 SHALL have port ready  input  1  downstream accepts the coordinate.
REQ-016 SHALL have port last  output  1  the current coordinate is the final one of the frame.
REQ-017 SHALL have port busy  output  1  high in RUN.
REQ-018 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-019 SHALL implement FSM states IDLE, RUN and DONE.
REQ-020 SHALL go IDLE->RUN on start when both latched dimensions are nonzero, and IDLE->DONE on start when either is zero, emitting no coordinates.
REQ-021 SHALL order coordinates with sample innermost, then x (0..W-1), then y (0..H-1), starting at (0,0,0).
REQ-022 SHALL drive valid high in every RUN cycle, with the first coordinate presented the cycle after start.
REQ-023 SHALL advance the coordinate only on a handshake (valid && ready) and hold all of x, y, sample_idx and last stable while valid && !ready.
REQ-024 SHALL wrap sample_idx to 0 and increment x after sample spp-1, and wrap x to 0 and increment y after column W-1.
REQ-025 SHALL assert last exactly when x=W-1, y=H-1 and sample_idx=spp_eff-1.
REQ-026 SHALL go RUN->DONE on the handshake of the last coordinate and DONE->IDLE unconditionally, with done high only in DONE.
REQ-027 SHALL on abort in RUN go to IDLE next cycle with valid low and no done pulse; abort takes priority over a coincident handshake.
REQ-028 SHALL treat abort in IDLE or DONE as no effect, and SHALL have start while busy or in DONE change no state.
REQ-029 SHALL form x and y as the zero-extended counter shifted left by FP_QW, with no saturation needed per REQ-003.
REQ-030 SHALL allow a new start in the cycle after DONE, giving back-to-back frames with one idle cycle.

Reset
REQ-031 SHALL on rst enter IDLE and clear all counters and latched configuration, with valid, last, busy and done at 0 and x, y, sample_idx at 0.
REQ-032 SHALL on rst asserted mid-frame drop valid immediately (asynchronously), without completing the in-flight coordinate or emitting done.

Configuration
REQ-033 SHALL, with RT_PIXEL_SEQ_STALL_CNT_EN defined, add port stall_cnt (output, 32 bits) that counts RUN cycles with valid && !ready, clears at start and reset, saturates at all-ones, and holds after the frame.
REQ-034 SHALL, without RT_PIXEL_SEQ_STALL_CNT_EN, have neither the port nor the counter logic, with all other behaviour identical.

Verification
REQ-035 SHALL cover: W=3, H=2, spp=1, ready=1 -> 6 coordinates (0,0)(1,0)(2,0)(0,1)(1,1)(2,1) on consecutive cycles, last only on (2,1), done the cycle after.
REQ-036 SHALL cover: W=2, H=1, spp=3 -> sample_idx 0,1,2 at x=0 then 0,1,2 at x=1; with spp=0 -> 2 coordinates.
REQ-037 SHALL cover: W=0, H=5, start -> no valid, done pulse, back in IDLE in 2 cycles.
REQ-038 SHALL cover: ready low for 4 cycles at (1,0) -> outputs stable, no skip or duplicate, and stall_cnt=4 when the macro is defined.
REQ-039 SHALL cover: abort at the 3rd coordinate -> valid low next cycle, no done; a new start then begins at (0,0,0).
REQ-040 SHALL cover: rst pulsed mid-frame -> valid and busy 0 immediately, all outputs at reset values; x for column 5 equals 5<<FP_QW.
